// File: rtl/joypad_responder.sv
// Console joypad shift-register responder: synchronizes the console latch/clock
// pins, captures filtered buttons (SOCD + turbo) and serializes them on jp_data_out.
module joypad_responder #(
  parameter int unsigned LATCH_ACTIVE_HIGH = 1,
  parameter int unsigned TURBO_HALF_PERIOD = 833333
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  input  logic [7:0] buttons_in,
  input  logic [1:0] turbo_en_in,
  output logic       jp_data_out,
  output logic [3:0] bit_count_out,
  output logic       poll_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned TURBO_CW = (TURBO_HALF_PERIOD > 1) ? $clog2(TURBO_HALF_PERIOD) : 1;
  localparam logic [TURBO_CW-1:0] TURBO_LAST = TURBO_CW'(TURBO_HALF_PERIOD - 1);

  logic [1:0]          state;
  logic [7:0]          shift_reg;
  logic [3:0]          bit_count;
  logic [2:0]          latch_pipe;
  logic [2:0]          clk_pipe;
  logic [TURBO_CW-1:0] turbo_cnt;
  logic                turbo_phase;
  logic                latch_level;
  logic                latch_sync;
  logic                latch_fall;
  logic                clk_rise;
  logic [7:0]          eff_buttons;

  // Latch pin is normalized to asserted-high before the synchronizer, so the
  // reset value 0 is the deasserted level regardless of pin polarity.
  assign latch_level = (LATCH_ACTIVE_HIGH != 0) ? jp_latch_in : !jp_latch_in;
  assign latch_sync  = latch_pipe[1];
  assign latch_fall  = latch_pipe[2] && !latch_pipe[1];
  assign clk_rise    = clk_pipe[1] && !clk_pipe[2];

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      latch_pipe <= '0;
      clk_pipe   <= '0;
    end else begin
      latch_pipe <= {latch_pipe[1:0], latch_level};
      clk_pipe   <= {clk_pipe[1:0], jp_clk_in};
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b1;
    end else if (turbo_cnt == TURBO_LAST) begin
      turbo_cnt   <= '0;
      turbo_phase <= !turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  always_comb begin
    eff_buttons = buttons_in;
    if (buttons_in[4] && buttons_in[5]) eff_buttons[5:4] = '0;
    if (buttons_in[6] && buttons_in[7]) eff_buttons[7:6] = '0;
    eff_buttons[0] = buttons_in[0] && (turbo_phase || !turbo_en_in[0]);
    eff_buttons[1] = buttons_in[1] && (turbo_phase || !turbo_en_in[1]);
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_count   <= '0;
      poll_out    <= 1'b0;
      jp_data_out <= 1'b1;
    end else begin
      poll_out    <= 1'b0;
      jp_data_out <= (state == ST_IDLE) ? 1'b1 : !shift_reg[0];
      // Latch level has priority over everything, so a coincident clock edge
      // in any state is dropped in favour of the reload.
      if (latch_sync) begin
        state     <= ST_LOAD;
        shift_reg <= eff_buttons;
      end else begin
        case (state)
          ST_LOAD: begin
            if (latch_fall) begin
              state     <= ST_SHIFT;
              poll_out  <= 1'b1;
              bit_count <= '0;
            end
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              shift_reg <= {1'b1, shift_reg[7:1]};
              bit_count <= bit_count + 4'd1;
              if (bit_count == 4'd7) state <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bit_count_out = bit_count;

endmodule

// File: tb/tb_joypad_responder.sv
// Randomized self-checking bench for joypad_responder against a behavioural
// model of button filtering, turbo phase and serial read order.
module tb_joypad_responder;

  localparam int unsigned TH = 4;

  logic       clk_25;
  logic       rst;
  logic       jp_latch_in;
  logic       jp_clk_in;
  logic [7:0] buttons_in;
  logic [1:0] turbo_en_in;
  logic       jp_data_out;
  logic [3:0] bit_count_out;
  logic       poll_out;

  int errors = 0;
  int checks = 0;
  int unsigned k = 0;
  int unsigned poll_cnt = 0;

  joypad_responder #(
    .LATCH_ACTIVE_HIGH(1),
    .TURBO_HALF_PERIOD(TH)
  ) dut (
    .clk_25       (clk_25),
    .rst          (rst),
    .jp_latch_in  (jp_latch_in),
    .jp_clk_in    (jp_clk_in),
    .buttons_in   (buttons_in),
    .turbo_en_in  (turbo_en_in),
    .jp_data_out  (jp_data_out),
    .bit_count_out(bit_count_out),
    .poll_out     (poll_out)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // Clock edges elapsed since reset release; the turbo phase is a pure function of it.
  always @(posedge clk_25 or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  always @(negedge clk_25) if (poll_out === 1'b1) poll_cnt++;

  function automatic logic [7:0] model_eff(input logic [7:0] b, input logic [1:0] en,
                                           input int unsigned kk);
    logic       ph;
    logic [7:0] r;
    ph = ((kk / TH) % 2) == 0;
    r = b;
    if (b[4] && b[5]) begin r[4] = 1'b0; r[5] = 1'b0; end
    if (b[6] && b[7]) begin r[6] = 1'b0; r[7] = 1'b0; end
    r[0] = b[0] && (ph || !en[0]);
    r[1] = b[1] && (ph || !en[1]);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic pulse(input int unsigned w);
    jp_clk_in = 1'b1;
    repeat (w) tick();
    jp_clk_in = 1'b0;
    repeat (w) tick();
  endtask

  task automatic latch_read(input logic [7:0] b, output logic [7:0] e);
    int unsigned p0;
    buttons_in  = b;
    jp_latch_in = 1'b1;
    repeat (5) tick();
    p0 = poll_cnt;
    jp_latch_in = 1'b0;
    e = model_eff(b, turbo_en_in, k + 1);
    repeat (5) tick();
    checks++;
    if (poll_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL poll_pulse: got %0d pulses expected 1", poll_cnt - p0);
    end
    checks++;
    if (bit_count_out !== 4'd0) begin
      errors++;
      $display("FAIL count_after_latch: got %0d expected 0", bit_count_out);
    end
  endtask

  task automatic read_bits(input logic [7:0] e, input int unsigned w, input string tag);
    logic exp_bit;
    for (int unsigned i = 0; i < 8; i++) begin
      exp_bit = ~e[i];
      checks++;
      if (jp_data_out !== exp_bit) begin
        errors++;
        $display("FAIL %s data bit %0d: got %b expected %b", tag, i, jp_data_out, exp_bit);
      end
      pulse(w);
      checks++;
      if (bit_count_out !== 4'(i + 1)) begin
        errors++;
        $display("FAIL %s count %0d: got %0d expected %0d", tag, i, bit_count_out, i + 1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    jp_latch_in = 1'b0;
    jp_clk_in = 1'b0;
    buttons_in = '0;
    turbo_en_in = '0;
    #1;
    checks++;
    if (jp_data_out !== 1'b1 || bit_count_out !== 4'd0 || poll_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%b count=%0d poll=%b expected 1/0/0",
               jp_data_out, bit_count_out, poll_out);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic_read;
    logic [7:0] e;
    turbo_en_in = 2'b00;
    latch_read(8'h81, e);
    read_bits(e, 12, "basic");
    for (int unsigned i = 0; i < 4; i++) begin
      pulse(12);
      checks++;
      if (jp_data_out !== 1'b0 || bit_count_out !== 4'd8) begin
        errors++;
        $display("FAIL saturate %0d: got data=%b count=%0d expected 0/8", i, jp_data_out, bit_count_out);
      end
    end
    latch_read(8'h81, e);
    checks++;
    if (jp_data_out !== ~e[0]) begin
      errors++;
      $display("FAIL relatch_data: got %b expected %b", jp_data_out, ~e[0]);
    end
  endtask

  task automatic test_socd;
    logic [7:0] e;
    logic [7:0] pats[3];
    pats[0] = 8'h30; pats[1] = 8'hC0; pats[2] = 8'h10;
    turbo_en_in = 2'b00;
    for (int unsigned p = 0; p < 3; p++) begin
      latch_read(pats[p], e);
      read_bits(e, 3, "socd");
    end
  endtask

  task automatic test_turbo;
    logic [7:0] e;
    logic       exp_bit;
    turbo_en_in = 2'b01;
    buttons_in  = 8'h03;
    jp_latch_in = 1'b1;
    repeat (6) tick();
    for (int unsigned i = 0; i < 16; i++) begin
      tick();
      e = model_eff(8'h03, 2'b01, k - 2);
      exp_bit = ~e[0];
      checks++;
      if (jp_data_out !== exp_bit) begin
        errors++;
        $display("FAIL turbo_a cycle %0d: got %b expected %b", i, jp_data_out, exp_bit);
      end
    end
    jp_latch_in = 1'b0;
    repeat (6) tick();
    latch_read(8'h03, e);
    read_bits(e, 3, "turbo_read");
    turbo_en_in = 2'b00;
  endtask

  task automatic test_coincident;
    logic [7:0] e;
    buttons_in  = 8'h01;
    jp_latch_in = 1'b1;
    repeat (5) tick();
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b1;
    e = model_eff(8'h01, turbo_en_in, k + 1);
    repeat (6) tick();
    checks++;
    if (bit_count_out !== 4'd0 || jp_data_out !== ~e[0]) begin
      errors++;
      $display("FAIL fall_with_edge: got count=%0d data=%b expected 0/%b",
               bit_count_out, jp_data_out, ~e[0]);
    end
    jp_clk_in = 1'b0;
    repeat (3) tick();
    read_bits(e, 3, "after_coincident");

    latch_read(8'h05, e);
    pulse(3);
    pulse(3);
    jp_latch_in = 1'b1;
    jp_clk_in   = 1'b1;
    repeat (6) tick();
    checks++;
    if (bit_count_out !== 4'd2) begin
      errors++;
      $display("FAIL latch_wins: got count=%0d expected 2", bit_count_out);
    end
    jp_clk_in = 1'b0;
    repeat (2) tick();
    jp_latch_in = 1'b0;
    e = model_eff(8'h05, turbo_en_in, k + 1);
    repeat (5) tick();
    read_bits(e, 3, "after_abort");
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] e;
    latch_read(8'h3C, e);
    pulse(3);
    pulse(3);
    pulse(3);
    rst = 1'b1;
    #1;
    checks++;
    if (jp_data_out !== 1'b1 || bit_count_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_abort: got data=%b count=%0d expected 1/0", jp_data_out, bit_count_out);
    end
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      pulse(3);
      checks++;
      if (jp_data_out !== 1'b1 || bit_count_out !== 4'd0) begin
        errors++;
        $display("FAIL idle_ignore %0d: got data=%b count=%0d expected 1/0", i, jp_data_out, bit_count_out);
      end
    end
    latch_read(8'h3C, e);
    read_bits(e, 3, "post_reset");
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    buttons_in  = 8'h01;
    jp_latch_in = 1'b1;
    repeat (5) tick();
    jp_latch_in = 1'b0;
    e = model_eff(8'h01, turbo_en_in, k + 1);
    repeat (4) tick();
    buttons_in = 8'h02;
    read_bits(e, 3, "late_change");
  endtask

  task automatic test_random;
    logic [7:0] e;
    for (int unsigned n = 0; n < 20; n++) begin
      turbo_en_in = 2'($urandom_range(0, 3));
      latch_read(8'($urandom), e);
      read_bits(e, 3 + $urandom_range(0, 2), "random");
      repeat ($urandom_range(0, 5)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_socd();
    test_turbo();
    test_coincident();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joypad_responder.md
JOYPAD_RESPONDER -- requirements
Module: joypad_responder

Interface
REQ-001 Parameter LATCH_ACTIVE_HIGH, default 1: jp_latch_in is asserted when high; 0 inverts the pin sense.
REQ-002 Parameter TURBO_HALF_PERIOD, default 833333: clk_25 cycles per turbo phase toggle, giving 15 Hz at 25 MHz.
REQ-003 clk_25  input  1  system clock, 25 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 jp_latch_in  input  1  latch pin driven by the console, asynchronous.
REQ-006 jp_clk_in  input  1  clock pin driven by the console, asynchronous.
REQ-007 buttons_in  input  8  active-high buttons, {Right,Left,Down,Up,Start,Select,B,A} as bit 7..0, synchronous to clk_25.
REQ-008 turbo_en_in  input  2  bit0 enables turbo on A; bit1 enables turbo on B.
REQ-009 jp_data_out  output  1  serial data pin; low = pressed.
REQ-010 bit_count_out  output  4  number of bits shifted since the last latch, 0..8, saturating.
REQ-011 poll_out  output  1  one-cycle pulse when latch deassertion is detected.

Function
REQ-012 jp_latch_in and jp_clk_in SHALL each pass through a 2-flop synchronizer plus 1 history flop; an edge is detected on the synchronized value, so total pin-to-event latency is 3 clk_25 cycles.
REQ-013 SOCD filter: when Up and Down are both pressed, both SHALL be masked to 0; Left and Right SHALL be filtered the same way.
REQ-014 Turbo phase SHALL be a free-running counter of 0..TURBO_HALF_PERIOD-1; the phase bit toggles at wrap; reset phase is 1.
REQ-015 Effective A SHALL be A & (phase | ~turbo_en_in[0]); effective B SHALL be computed the same way using turbo_en_in[1].
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; the reset state is IDLE.
REQ-017 Any state SHALL go to LOAD when the synchronized latch is asserted; while in LOAD, the 8-bit shift register reloads every cycle with the effective buttons.
REQ-018 LOAD SHALL go to SHIFT on the synchronized latch deassertion cycle, with the register holding the final reload value; poll_out pulses in that cycle and bit_count is cleared to 0.
REQ-019 In SHIFT, each synchronized rising edge of jp_clk SHALL shift the register right, fill bit 7 with 1, and increment bit_count; the FSM goes to DONE when bit_count reaches 8.
REQ-020 In DONE, clock edges SHALL be ignored, bit_count stays at 8, and the register remains all ones, so jp_data_out is low.
REQ-021 jp_data_out SHALL be registered and equal to ~shift_reg[0], updating 1 cycle after the register changes; in IDLE it is held at 1.
REQ-022 Clock edges SHALL be ignored in IDLE and LOAD.
REQ-023 If a clock rising edge and latch deassertion are detected in the same cycle, the edge SHALL be ignored (no shift; bit_count = 0).
REQ-024 If a clock edge and latch assertion are detected in the same cycle, the latch SHALL win: the FSM goes to LOAD with no shift.
REQ-025 A latch re-assertion in SHIFT or DONE SHALL abort the read and go to LOAD.
REQ-026 Changes on buttons_in after latch deassertion SHALL NOT affect the shifted data until the next latch.
REQ-027 Turbo, SOCD filtering and the synchronizers SHALL operate identically in every FSM state.

Reset
REQ-028 While rst is high, the block SHALL hold: state IDLE, shift register 0x00, bit_count_out 0, jp_data_out 1, poll_out 0, turbo counter 0, phase 1, and all synchronizer flops at the deasserted level.
REQ-029 Reset asserted mid-read SHALL abort immediately; after release, no shifting occurs until a complete latch assert/deassert is seen.

Verification
REQ-030 buttons=0x81 (A, Right), turbo off; latch, then 8 clock pulses (each 12 cycles wide) -> jp_data_out sequence 0,1,1,1,1,1,1,0; bit_count 1..8; a single poll_out pulse.
REQ-031 After the 8th clock pulse, apply 4 more pulses -> jp_data_out stays 0 and bit_count stays 8; a new latch -> bit_count 0 and data = ~A.
REQ-032 buttons=0x30 (Up+Down), then 0xC0 (Left+Right) -> all 8 serial bits read 1 (released); buttons=0x10 -> bit 4 reads 0.
REQ-033 TURBO_HALF_PERIOD=4 in the bench, turbo_en=01, A held, latch every 3 cycles -> the A bit alternates pressed/released every 4 cycles, starting pressed; B is unaffected.
REQ-034 Clock rising edge coincident with latch fall -> no shift and bit_count 0; rst pulsed after 3 shifts -> jp_data_out 1 within the same cycle; clock pulses then ignored until the next latch.
REQ-035 buttons_in changes from 0x01 to 0x02 one cycle after latch deassertion is detected -> serial data reflects 0x01.
